// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // Baud counter; restart holds it at zero so the next period starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (restart) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == TERM) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == TERM) && !restart;

endmodule

// File: rtl/uart_tx64.sv
// 8N1 UART transmitter sending an N-bit word as N/8 back-to-back frames, LSB byte first.
module uart_tx64
  import uart_pkg::*;
#(
  parameter int N            = 64,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int NBYTES = N / UART_DATA_BITS;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  uart_tx_state_t state_r, state_nxt_s;
  logic [N-1:0]   shreg_r, shreg_nxt_s;
  logic [2:0]     bit_cnt_r, bit_cnt_nxt_s;
  logic [BW-1:0]  byte_cnt_r, byte_cnt_nxt_s;
  logic           tx_r, tx_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic           done_r, done_nxt_s;
  logic           tick_s;
  logic [2:0]     bit_inc_s;
  logic [7:0]     cur_byte_s;

  // Counter is held in IDLE; every other state change lands on a tick, where it wraps to 0.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(state_r == IDLE),
    .tick   (tick_s)
  );

  assign bit_inc_s  = bit_cnt_r + 3'd1;
  assign cur_byte_s = shreg_r[7:0];

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= {N{1'b0}};
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= {BW{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shreg_r    <= shreg_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  // Next-state logic; tx is computed for the coming cycle so the pin comes straight off a flop.
  always_comb begin
    state_nxt_s    = state_r;
    shreg_nxt_s    = shreg_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    byte_cnt_nxt_s = byte_cnt_r;
    tx_nxt_s       = 1'b1;
    busy_nxt_s     = 1'b1;
    done_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s    = START;
          shreg_nxt_s    = data;
          bit_cnt_nxt_s  = 3'd0;
          byte_cnt_nxt_s = {BW{1'b0}};
          tx_nxt_s       = 1'b0;
        end else begin
          busy_nxt_s     = 1'b0;
        end
      end
      START: begin
        if (tick_s) begin
          state_nxt_s   = DATA;
          bit_cnt_nxt_s = 3'd0;
          tx_nxt_s      = cur_byte_s[0];
        end else begin
          tx_nxt_s      = 1'b0;
        end
      end
      DATA: begin
        if (!tick_s) begin
          tx_nxt_s      = cur_byte_s[bit_cnt_r];
        end else if (bit_cnt_r == 3'd7) begin
          state_nxt_s   = STOP;
          tx_nxt_s      = 1'b1;
        end else begin
          bit_cnt_nxt_s = bit_inc_s;
          tx_nxt_s      = cur_byte_s[bit_inc_s];
        end
      end
      STOP: begin
        if (!tick_s) begin
          tx_nxt_s       = 1'b1;
        end else if (byte_cnt_r == LAST_BYTE) begin
          state_nxt_s    = IDLE;
          busy_nxt_s     = 1'b0;
          done_nxt_s     = 1'b1;
        end else begin
          state_nxt_s    = START;
          byte_cnt_nxt_s = byte_cnt_r + BW'(1);
          shreg_nxt_s    = shreg_r >> 8;
          tx_nxt_s       = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx64.sv
// Directed bench for uart_tx64 with CLKS_PER_BIT=4, N=64.
module tb_uart_tx64;

  localparam int CPB  = 4;
  localparam int WORD = 80 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] data = 64'h0;
  logic        tx, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  logic tx_log   [0:799];
  logic busy_log [0:799];
  logic done_log [0:799];

  uart_tx64 #(.N(64), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected line level i cycles after the start edge of word d.
  function automatic logic exp_tx(input logic [63:0] d, input int i);
    int p, f, pos;
    p = i / CPB; f = p / 10; pos = p % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return d[f*8 + pos - 1];
  endfunction

  function automatic int stream_errs(input logic [63:0] d, input int base);
    int e = 0;
    for (int i = 0; i < WORD; i++) if (tx_log[base+i] !== exp_tx(d, i)) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode_byte(input int base, input int f);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tx_log[base + (f*10 + 1 + k)*CPB + CPB/2];
    return b;
  endfunction

  task automatic launch(input logic [63:0] d);
    @(negedge clk);
    data = d;
    start = 1'b1;
  endtask

  task automatic capture(input int n, input int start_off_at, input int inject_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == start_off_at) start = 1'b0;
      if (inject_at >= 0 && i == inject_at) begin data = 64'hFF; start = 1'b1; end
      if (inject_at >= 0 && i == inject_at + 1) start = 1'b0;
      tx_log[i] = tx; busy_log[i] = busy; done_log[i] = done;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    #20 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_idle: %0d cycles not idle, required 0", bad); end
  endtask

  task automatic check_word(input string nm, input logic [63:0] d, input int base);
    int e, nb, nd, di;
    e = stream_errs(d, base);
    n_cmp++;
    if (e != 0) begin n_fail++; $display("FAIL %s_stream: %0d cycle errors, required 0", nm, e); end
    nb = 0; nd = 0; di = -1;
    for (int i = 0; i < WORD + 2; i++) begin
      if (busy_log[base+i] === 1'b1) nb++;
      if (done_log[base+i] === 1'b1) begin nd++; di = i; end
    end
    n_cmp++;
    if (nb != WORD) begin n_fail++; $display("FAIL %s_busy_len: %0d cycles, required %0d", nm, nb, WORD); end
    n_cmp++;
    if (nd != 1 || di != WORD || busy_log[base+WORD] !== 1'b0) begin
      n_fail++; $display("FAIL %s_done: count=%0d at=%0d, required 1 at %0d with busy low", nm, nd, di, WORD);
    end
  endtask

  task automatic test_single_word();
    logic [63:0] d;
    logic [7:0]  exp_b [0:7];
    d = 64'h0123456789ABCDEF;
    exp_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    launch(d);
    capture(WORD + 2, 0, -1);
    for (int f = 0; f < 8; f++) begin
      n_cmp++;
      if (decode_byte(0, f) !== exp_b[f]) begin
        n_fail++; $display("FAIL single_byte%0d: got %h, required %h", f, decode_byte(0, f), exp_b[f]);
      end
    end
    check_word("single", d, 0);
    n_cmp++;
    if (tx_log[WORD+1] !== 1'b1) begin n_fail++; $display("FAIL single_idle_after: tx=%b required 1", tx_log[WORD+1]); end
  endtask

  task automatic test_bit_framing();
    logic [9:0] pat;
    int bad;
    pat = 10'b1010101010;
    launch(64'h55);
    capture(WORD + 2, 0, -1);
    for (int p = 0; p < 10; p++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) if (tx_log[p*CPB + c] !== pat[p]) bad++;
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL framing_bit%0d: %0d samples off, required level %b", p, bad, pat[p]); end
    end
    for (int f = 1; f < 8; f++) begin
      n_cmp++;
      if (decode_byte(0, f) !== 8'h00) begin
        n_fail++; $display("FAIL framing_byte%0d: got %h, required 00", f, decode_byte(0, f));
      end
    end
  endtask

  task automatic test_busy_ignore();
    launch(64'h0);
    capture(WORD + 20, 0, 10);
    check_word("ignore", 64'h0, 0);
    for (int i = WORD + 1; i < WORD + 20; i++) begin
      if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) begin
        n_cmp++; n_fail++;
        $display("FAIL ignore_queued: activity at cycle %0d, required idle", i);
        break;
      end
    end
  endtask

  task automatic test_midframe_reset();
    int bad = 0;
    launch(64'hFFFF_FFFF_FFFF_FFFF);
    capture((3*10 + 1 + 4)*CPB + 2, 0, -1);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL midreset_idle: %0d cycles not idle, required 0", bad); end
    launch(64'hA5);
    capture(WORD + 2, 0, -1);
    n_cmp++;
    if (decode_byte(0, 0) !== 8'hA5) begin
      n_fail++; $display("FAIL midreset_byte0: got %h, required a5", decode_byte(0, 0));
    end
    check_word("midreset", 64'hA5, 0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, d2;
    d1 = 64'hAAAA_5555_F0F0_0F0F;
    d2 = 64'h5555_AAAA_0F0F_F0F0;
    launch(d1);
    @(negedge clk);
    data = d2;
    tx_log[0] = tx; busy_log[0] = busy; done_log[0] = done;
    for (int i = 1; i < 2*(WORD + 1) + 1; i++) begin
      @(negedge clk);
      if (i == WORD + 1) start = 1'b0;
      tx_log[i] = tx; busy_log[i] = busy; done_log[i] = done;
    end
    n_cmp++;
    if (stream_errs(d1, 0) != 0) begin n_fail++; $display("FAIL b2b_word1: %0d cycle errors, required 0", stream_errs(d1, 0)); end
    n_cmp++;
    if (done_log[WORD] !== 1'b1 || tx_log[WORD] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done1: done=%b tx=%b at %0d, required 1 1", done_log[WORD], tx_log[WORD], WORD);
    end
    n_cmp++;
    if (tx_log[WORD+1] !== 1'b0 || busy_log[WORD+1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: tx=%b busy=%b one cycle after done, required 0 1", tx_log[WORD+1], busy_log[WORD+1]);
    end
    check_word("b2b_word2", d2, WORD + 1);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bit_framing();
    test_busy_ignore();
    test_midframe_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
